csr_access_unit: RTL

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit_pkg.sv | 24 ++
 rtl/csr_access_unit_rsp_buffer.sv | 37 +++
 rtl/csr_access_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - shared gpu definitions: CSR op encoding and FPU CSR addresses
package csr_access_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RW = 2'd0,
        CSR_OP_RS = 2'd1,
        CSR_OP_RC = 2'd2
    } csr_op_e;

    localparam logic [11:0] CSR_FFLAGS    = 12'h001;
    localparam logic [11:0] CSR_FRM       = 12'h002;
    localparam logic [11:0] CSR_FCSR      = 12'h003;
    localparam logic [1:0]  CSR_RO_PREFIX = 2'b11;

    // FP CSRs must not be touched while the owning warp still has FP ops in flight
    function automatic logic is_fpu_csr(input logic [11:0] addr);
        return (addr == CSR_FFLAGS) || (addr == CSR_FRM) || (addr == CSR_FCSR);
    endfunction

    function automatic logic is_ro_csr(input logic [11:0] addr);
        return addr[11:10] == CSR_RO_PREFIX;
    endfunction

endpackage

// File: rtl/csr_access_unit_rsp_buffer.sv
// rtl/csr_access_unit_rsp_buffer.sv - single-entry valid/ready pipeline register for CSR responses
module csr_rsp_buffer #(
    parameter int DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data
);

    logic             valid_q;
    logic [DATAW-1:0] data_q;

    // A consumed entry can be replaced in the same cycle, so no bubble between responses
    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_q <= in_data;
        end
    end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - CSR read-modify-write unit with FPU-CSR hazard stall and registered response
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int NW_WIDTH    = 2
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [UUID_WIDTH-1:0]               req_uuid,
    input  logic [NW_WIDTH-1:0]                 req_wid,
    input  logic [NUM_THREADS-1:0]              req_tmask,
    input  logic [XLEN-1:0]                     req_pc,
    input  logic [4:0]                          req_rd,
    input  logic [1:0]                          req_op,
    input  logic                                req_use_imm,
    input  logic [4:0]                          req_imm,
    input  logic                                req_rs1_is_x0,
    input  logic [NUM_THREADS-1:0][XLEN-1:0]    req_rs1_data,
    input  logic [11:0]                         req_addr,

    output logic                                csr_read_enable,
    output logic [UUID_WIDTH-1:0]               csr_read_uuid,
    output logic [NW_WIDTH-1:0]                 csr_read_wid,
    output logic [11:0]                         csr_read_addr,
    input  logic [XLEN-1:0]                     csr_read_data_ro,
    input  logic [XLEN-1:0]                     csr_read_data_rw,

    output logic                                csr_write_enable,
    output logic [UUID_WIDTH-1:0]               csr_write_uuid,
    output logic [NW_WIDTH-1:0]                 csr_write_wid,
    output logic [11:0]                         csr_write_addr,
    output logic [XLEN-1:0]                     csr_write_data,

    input  logic [NUM_WARPS-1:0]                fpu_pending,

    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [UUID_WIDTH-1:0]               rsp_uuid,
    output logic [NW_WIDTH-1:0]                 rsp_wid,
    output logic [NUM_THREADS-1:0]              rsp_tmask,
    output logic [XLEN-1:0]                     rsp_pc,
    output logic [4:0]                          rsp_rd,
    output logic                                rsp_wb,
    output logic [NUM_THREADS-1:0][XLEN-1:0]    rsp_data,

    output logic                                illegal_write
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_FPU = 1'b1;

    localparam int PAYLOAD_W = UUID_WIDTH + NW_WIDTH + NUM_THREADS + XLEN + 5 + 1 + XLEN;

    if (CORE_ID < 0 || NUM_WARPS > (1 << NW_WIDTH) || XLEN < 5) begin : g_bad_params
        $error("csr_access_unit: inconsistent parameters");
    end

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic                 hazard;
    logic                 warp_fpu_busy;
    logic                 fire;
    logic                 rsp_in_ready;
    logic [XLEN-1:0]      rs1_sel;
    logic [XLEN-1:0]      src;
    logic [XLEN-1:0]      old_value;
    logic [XLEN-1:0]      new_value;
    logic                 write_intent;
    logic                 ro_target;
    logic [PAYLOAD_W-1:0] rsp_in_data;
    logic [PAYLOAD_W-1:0] rsp_out_data;
    logic [XLEN-1:0]      rsp_old;

    assign warp_fpu_busy = fpu_pending[req_wid];
    assign hazard        = is_fpu_csr(req_addr) & warp_fpu_busy;

    // Gating by reset keeps every CSR side effect quiet while reset is held
    assign req_ready = ~reset & (state == ST_IDLE) & ~hazard & rsp_in_ready;
    assign fire      = req_valid & req_ready;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (req_valid && hazard) state_next = ST_WAIT_FPU;
            ST_WAIT_FPU: if (!warp_fpu_busy)      state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Lowest active lane supplies rs1; an empty mask falls back to lane 0
    always_comb begin
        rs1_sel = req_rs1_data[0];
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (req_tmask[i]) rs1_sel = req_rs1_data[i];
        end
    end

    assign src       = req_use_imm ? {{(XLEN-5){1'b0}}, req_imm} : rs1_sel;
    assign old_value = csr_read_data_ro | csr_read_data_rw;

    always_comb begin
        new_value = old_value;
        case (req_op)
            CSR_OP_RW: new_value = src;
            CSR_OP_RS: new_value = old_value | src;
            CSR_OP_RC: new_value = old_value & ~src;
            default:   new_value = old_value;
        endcase
    end

    // csrrs/csrrc with a zero source are pure reads and must not cause write side effects
    assign write_intent = (req_op == CSR_OP_RW)
                        | (req_use_imm ? (req_imm != 5'd0) : ~req_rs1_is_x0);
    assign ro_target    = is_ro_csr(req_addr);

    assign csr_read_enable  = fire;
    assign csr_read_uuid    = req_uuid;
    assign csr_read_wid     = req_wid;
    assign csr_read_addr    = req_addr;

    assign csr_write_enable = fire & write_intent & ~ro_target;
    assign csr_write_uuid   = req_uuid;
    assign csr_write_wid    = req_wid;
    assign csr_write_addr   = req_addr;
    assign csr_write_data   = new_value;

    assign illegal_write    = fire & write_intent & ro_target;

    assign rsp_in_data = {req_uuid, req_wid, req_tmask, req_pc, req_rd, (req_rd != 5'd0), old_value};

    csr_rsp_buffer #(
        .DATAW (PAYLOAD_W)
    ) u_rsp_buffer (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fire),
        .in_ready  (rsp_in_ready),
        .in_data   (rsp_in_data),
        .out_valid (rsp_valid),
        .out_ready (rsp_ready),
        .out_data  (rsp_out_data)
    );

    assign {rsp_uuid, rsp_wid, rsp_tmask, rsp_pc, rsp_rd, rsp_wb, rsp_old} = rsp_out_data;

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            rsp_data[i] = rsp_old;
        end
    end

endmodule
